count_display: RTL and testbench
================================

Name: count_display

Overview:
- Display stage directly downstream of the dual debounced/noisy push counters.
- Takes the two true (non-inverted) 7-bit counts and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Left digit pair shows the noisy count; right digit pair shows the debounced count.
- Shows each count in hex, or in decimal with an overflow indicator. Decimal conversion is done by a sequential shift-add (double-dabble) engine that runs continuously.

Parameters:
- REFRESH_BITS, 17, width of the refresh counter; each digit is lit for 2^(REFRESH_BITS-2) cycles.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- noisyCount  in  7  noisy push count, true polarity
- debouncedCount  in  7  debounced push count, true polarity
- decMode  in  1  0 = hex display, 1 = decimal display
- anode  out  4  digit enables, active-low; [3] is leftmost
- segment  out  8  {dp,g,f,e,d,c,b,a}, active-low
- convBusy  out  1  high while the converter is mid-channel

Behaviour:
- Reset (reset==0 at a posedge):
  - anode=4'b1111, segment=8'hFF, convBusy=0.
  - Refresh counter=0, FSM=IDLE, channel select=0.
  - All four stored digits=0, both overflow flags=0.
- Channel mapping: channel 0 = noisyCount → digits 3,2; channel 1 = debouncedCount → digits 1,0.
- Converter FSM, per channel:
  - IDLE (1 cycle) → LOAD.
  - LOAD: sample the channel input into v.
    - If decMode and v>=100: w=v-100, ovf=1; otherwise w=v, ovf=0.
    - bcd=8'h00, shift count=0, convBusy=1.
  - SHIFT (7 cycles): each cycle, first add 3 to any BCD nibble >=5, then shift {bcd,w} left by 1. Leave after the count reaches 7.
  - STORE (1 cycle):
    - decMode: digit pair = bcd[7:4], bcd[3:0]; overflow flag = ovf.
    - Hex mode: digit pair = {1'b0,v[6:4]}, v[3:0]; overflow flag = 0.
    - Toggle channel; convBusy=0.
    - Go to LOAD if the channel was 0, else IDLE.
- Cycle budget: 1+1+7+1+1+7+1 = 19 cycles per full two-channel refresh, repeating forever.
- Stored digits for a channel change only in STORE, atomically as a pair; the display never shows a half-updated pair.
- Latency: an input change is visible no later than 2×19 cycles plus the current digit's remaining scan slot.
- Inputs are sampled only in LOAD. A change during SHIFT does not affect the conversion in flight.
- decMode is sampled in LOAD and used again in STORE for the same channel. A decMode change mid-conversion takes effect on the next LOAD.
- Boundary values:
  - Decimal: 0→"00"; 99→"99", dp off; 100→"00", dp on; 127→"27", dp on.
  - Hex: 127→"7F".
- Refresh counter:
  - REFRESH_BITS wide, increments every cycle, wraps silently.
  - Digit select = top 2 bits; select d drives anode bit d low, all others high.
- Segment encoding: combinational decode of the selected stored digit, registered once.
  - Hex font 0-F.
  - dp (segment[7]) = 0 (lit) only on digits 3 and 1, when that channel's overflow flag is set.
- anode and segment are registered together, so both change on the same edge. One cycle of latency from the refresh counter.
- Reset mid-conversion: abandon the conversion and clear the stored digits. Restart at IDLE on channel 0 after reset deasserts.

Decomposition:
- Package count_display_pkg:
  - conv_state_t enum {IDLE, LOAD, SHIFT, STORE}.
  - Constant DEC_OVF_THRESH=100.
  - Function seg_decode(logic[3:0]) returning the active-low 7-segment pattern.
- Sub-module bin2bcd_seq: the LOAD/SHIFT engine.
  - Ports: clk, reset, start, value[6:0], bcd[7:0], done.
  - count_display keeps the channel sequencing, storage, refresh and segment output.

Test Plan (REFRESH_BITS=4):
- Reset held 3 cycles with arbitrary inputs → anode=1111, segment=FF, convBusy=0 throughout; first conversion LOAD occurs 2 cycles after release.
- decMode=0, noisy=7'h7F, debounced=7'h0A, wait 40 cycles → scan shows digit 3 seg for 7 (8'hF8), digit 2 F (8'h8E), digit 1 0 (8'hC0), digit 0 A (8'h88); dp never lit.
- decMode=1, noisy=99, debounced=100 → digits "9","9","0","0"; dp lit only while anode=0111 is false and anode=1101 is active (segment[7]=0 on digit 1 only).
- decMode=1, noisy=127, debounced=0 → "2","7" with dp on digit 3, then "0","0".
- Change noisy 5→6 during channel-0 SHIFT → that STORE still holds 5; 6 appears after the next channel-0 STORE (≤19 cycles later).
- Assert reset mid-SHIFT → next edge: all outputs at reset values; after release, the first channel-0 STORE occurs exactly 10 cycles after reset deasserts.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared types, constants and the seven-segment font for the count display.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } conv_state_t;

    // Decimal mode shows two digits; values at or above this wrap and light dp.
    localparam logic [6:0] DEC_OVF_THRESH = 7'd100;

    // One shift per input bit of the 7-bit count.
    localparam int BCD_SHIFTS = 7;

    // Active-low {g,f,e,d,c,b,a} pattern for a hex digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary (0..99) to two BCD digits.
// done is high during the cycle that performs the final shift, so bcd is
// complete on the cycle after done.
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] value,
    output logic [7:0] bcd,
    output logic       done
);

    logic [14:0] shreg_q, shreg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [7:0]  bcd_adj;

    // Add 3 to each BCD nibble that is 5 or more before it is doubled.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (shreg_q[7 + gi*4 +: 4] >= 4'd5)
                                      ? shreg_q[7 + gi*4 +: 4] + 4'd3
                                      : shreg_q[7 + gi*4 +: 4];
        end
    endgenerate

    // Load on start, otherwise adjust-and-shift until all input bits are consumed.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start) begin
            shreg_d = {8'h00, value};
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            shreg_d = {bcd_adj, shreg_q[6:0]} << 1;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'(BCD_SHIFTS - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign bcd  = shreg_q[14:7];
    assign done = busy_q && (cnt_q == 3'(BCD_SHIFTS - 1));

endmodule

// File: rtl/count_display.sv
// Two-channel count display: converts the noisy and debounced counts in turn
// and scans them onto a 4-digit common-anode seven-segment display.
module count_display
    import count_display_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] noisyCount,
    input  logic [6:0] debouncedCount,
    input  logic       decMode,
    output logic [3:0] anode,
    output logic [7:0] segment,
    output logic       convBusy
);

    conv_state_t            state_q, state_d;
    logic                   chan_q, chan_d;
    logic [6:0]             v_q, v_d;
    logic                   ovf_q, ovf_d;
    logic                   dec_q, dec_d;
    logic                   busy_q, busy_d;
    logic [3:0][3:0]        digits_q, digits_d;
    logic [1:0]             ovf_flag_q, ovf_flag_d;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [3:0]             anode_q, anode_d;
    logic [7:0]             segment_q, segment_d;

    logic [6:0] chan_in;
    logic       over;
    logic [6:0] conv_value;
    logic [7:0] conv_bcd;
    logic       conv_done;
    logic [3:0] pair_hi, pair_lo;
    logic [1:0] sel;
    logic       dp_lit;

    // Channel 0 feeds the left pair (noisy), channel 1 the right pair (debounced).
    assign chan_in    = chan_q ? debouncedCount : noisyCount;
    assign over       = decMode && (chan_in >= DEC_OVF_THRESH);
    assign conv_value = over ? (chan_in - DEC_OVF_THRESH) : chan_in;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (state_q == LOAD),
        .value (conv_value),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Digit pair to commit, using the mode captured when the channel was loaded.
    assign pair_hi = dec_q ? conv_bcd[7:4] : {1'b0, v_q[6:4]};
    assign pair_lo = dec_q ? conv_bcd[3:0] : v_q[3:0];

    // Channel sequencer: IDLE, then LOAD/SHIFT/STORE for channel 0 and channel 1.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        v_d        = v_q;
        ovf_d      = ovf_q;
        dec_d      = dec_q;
        busy_d     = busy_q;
        digits_d   = digits_q;
        ovf_flag_d = ovf_flag_q;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                v_d     = chan_in;
                ovf_d   = over;
                dec_d   = decMode;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (conv_done) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                if (!chan_q) begin
                    digits_d[3]   = pair_hi;
                    digits_d[2]   = pair_lo;
                    ovf_flag_d[0] = dec_q && ovf_q;
                end else begin
                    digits_d[1]   = pair_hi;
                    digits_d[0]   = pair_lo;
                    ovf_flag_d[1] = dec_q && ovf_q;
                end
                chan_d  = ~chan_q;
                busy_d  = 1'b0;
                state_d = chan_q ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and stored-digit registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            chan_q     <= 1'b0;
            v_q        <= '0;
            ovf_q      <= 1'b0;
            dec_q      <= 1'b0;
            busy_q     <= 1'b0;
            digits_q   <= '0;
            ovf_flag_q <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            v_q        <= v_d;
            ovf_q      <= ovf_d;
            dec_q      <= dec_d;
            busy_q     <= busy_d;
            digits_q   <= digits_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    // Scan: the top two refresh bits pick the digit being lit.
    assign sel    = refresh_q[REFRESH_BITS-1 -: 2];
    assign dp_lit = ((sel == 2'd3) && ovf_flag_q[0]) || ((sel == 2'd1) && ovf_flag_q[1]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign anode_d[gi] = (sel != 2'(gi));
        end
    endgenerate

    assign segment_d = {~dp_lit, seg_decode(digits_q[sel])};

    // Free-running refresh counter and the registered anode/segment pair.
    always_ff @(posedge clk) begin
        if (!reset) begin
            refresh_q <= '0;
            anode_q   <= 4'b1111;
            segment_q <= 8'hFF;
        end else begin
            refresh_q <= refresh_q + REFRESH_BITS'(1);
            anode_q   <= anode_d;
            segment_q <= segment_d;
        end
    end

    assign anode    = anode_q;
    assign segment  = segment_q;
    assign convBusy = busy_q;

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display with a short refresh counter.
module tb_count_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] noisyCount = 7'h55;
    logic [6:0] debouncedCount = 7'h2A;
    logic       decMode = 1'b1;
    logic [3:0] anode;
    logic [7:0] segment;
    logic       convBusy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    count_display #(.REFRESH_BITS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .noisyCount     (noisyCount),
        .debouncedCount (debouncedCount),
        .decMode        (decMode),
        .anode          (anode),
        .segment        (segment),
        .convBusy       (convBusy)
    );

    typedef struct packed {
        logic            dec;
        logic [6:0]      noisy;
        logic [6:0]      deb;
        logic [3:0][7:0] seg;   // expected segment byte, index = digit number
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    vec_t vecs [7];
    exp_t sb_q [$];

    function automatic vec_t mk(input logic dec, input logic [6:0] n, input logic [6:0] d,
                                input logic [7:0] s3, input logic [7:0] s2,
                                input logic [7:0] s1, input logic [7:0] s0);
        vec_t v;
        v.dec   = dec;
        v.noisy = n;
        v.deb   = d;
        v.seg   = {s3, s2, s1, s0};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Pop the next expected digit, wait for it to be scanned, compare its segments.
    task automatic observe(input string name);
        exp_t e;
        int   waited;
        e = sb_q.pop_front();
        waited = 0;
        while (anode !== e.an && waited < 24) begin
            @(negedge clk);
            waited++;
        end
        if (anode !== e.an) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: anode stuck at %b, expected %b to appear", name, anode, e.an);
        end else begin
            check(name, {24'h0, segment}, {24'h0, e.seg});
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] an;
        int         waited;
        exp_t       e;

        vecs[0] = mk(1'b0, 7'h7F, 7'h0A, 8'hF8, 8'h8E, 8'hC0, 8'h88);
        vecs[1] = mk(1'b1, 7'd99, 7'd100, 8'h90, 8'h90, 8'h40, 8'hC0);
        vecs[2] = mk(1'b1, 7'd127, 7'd0, 8'h24, 8'hF8, 8'hC0, 8'hC0);
        vecs[3] = mk(1'b1, 7'd0, 7'd99, 8'hC0, 8'hC0, 8'h90, 8'h90);
        vecs[4] = mk(1'b0, 7'h5A, 7'h3C, 8'h92, 8'h88, 8'hB0, 8'hC6);
        vecs[5] = mk(1'b1, 7'd45, 7'd63, 8'h99, 8'h92, 8'h82, 8'hB0);
        vecs[6] = mk(1'b0, 7'd100, 7'd100, 8'h82, 8'h99, 8'h82, 8'h99);

        // Reset held for three edges: outputs idle throughout.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_anode", {28'h0, anode}, 32'hF);
            check("rst_segment", {24'h0, segment}, 32'hFF);
            check("rst_busy", {31'h0, convBusy}, 32'h0);
        end
        reset = 1'b1;
        step(1);
        check("busy_idle_after_release", {31'h0, convBusy}, 32'h0);
        step(1);
        check("busy_after_first_load", {31'h0, convBusy}, 32'h1);
        $display("reset sequence done");

        // Steady-state patterns from the table.
        for (int i = 0; i < 7; i++) begin
            decMode        = vecs[i].dec;
            noisyCount     = vecs[i].noisy;
            debouncedCount = vecs[i].deb;
            for (int d = 3; d >= 0; d--) begin
                an       = 4'b0001 << d;
                e.an     = ~an;
                e.seg    = vecs[i].seg[d];
                sb_q.push_back(e);
            end
            step(45);
            for (int d = 3; d >= 0; d--) begin
                observe($sformatf("vec%0d_digit%0d", i, d));
            end
            $display("vec %0d dec=%0d noisy=%0d deb=%0d checked", i, vecs[i].dec,
                     vecs[i].noisy, vecs[i].deb);
        end

        // Reset in the middle of a conversion.
        decMode        = 1'b0;
        noisyCount     = 7'h33;
        debouncedCount = 7'h11;
        step(45);
        waited = 0;
        while (convBusy !== 1'b0 && waited < 30) begin step(1); waited++; end
        while (convBusy !== 1'b1 && waited < 60) begin step(1); waited++; end
        check("busy_seen_before_midreset", {31'h0, convBusy}, 32'h1);
        step(2);
        reset = 1'b0;
        step(1);
        check("midrst_anode", {28'h0, anode}, 32'hF);
        check("midrst_segment", {24'h0, segment}, 32'hFF);
        check("midrst_busy", {31'h0, convBusy}, 32'h0);
        step(1);
        noisyCount = 7'd5;
        reset      = 1'b1;
        // Channel 0 loads on the second edge after release; change input mid-SHIFT.
        step(3);
        noisyCount = 7'd6;
        step(7);
        check("cleared_digit2_anode", {28'h0, anode}, 32'hB);
        check("cleared_digit2_before_store", {24'h0, segment}, 32'hC0);
        step(1);
        check("store_at_10_anode", {28'h0, anode}, 32'hB);
        check("store_at_10_segment", {24'h0, segment}, 32'h92);
        step(17);
        check("inflight_kept_anode", {28'h0, anode}, 32'hB);
        check("inflight_kept_segment", {24'h0, segment}, 32'h92);
        step(16);
        check("next_store_anode", {28'h0, anode}, 32'hB);
        check("next_store_segment", {24'h0, segment}, 32'h82);
        $display("mid-conversion reset and input-change sequence done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
